// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: one countdown entry per architectural register,
// producing RAW/WAW issue stalls and bypass-tap selection for two sources.

module hazard_scoreboard_entry #(
  parameter int MAXLAT   = 8,
  parameter int LATW     = 4,
  parameter int KILL_WIN = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            hold,
  input  logic            flush,
  input  logic            load,
  input  logic [LATW-1:0] load_cnt,
  output logic            busy,
  output logic [LATW-1:0] cnt
);
  logic [LATW-1:0] age;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      age  <= '0;
    end else if (!hold) begin
      // a fresh issue overrides an entry expiring on the same edge
      if (load) begin
        busy <= 1'b1;
        cnt  <= load_cnt;
        age  <= '0;
      end else if (busy) begin
        if (flush && int'(age) < KILL_WIN) begin
          busy <= 1'b0;
          cnt  <= '0;
          age  <= '0;
        end else begin
          cnt  <= cnt - 1'b1;
          age  <= (age == LATW'(MAXLAT)) ? age : age + 1'b1;
          busy <= (cnt != LATW'(1));
        end
      end
    end
  end
endmodule

module hazard_scoreboard #(
  parameter int NREGS    = 32,
  parameter int ADDRW    = $clog2(NREGS),
  parameter int MAXLAT   = 8,
  parameter int LATW     = $clog2(MAXLAT+1),
  parameter int FWD_WIN  = 2,
  parameter int KILL_WIN = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_wen,
  input  logic [ADDRW-1:0] issue_rd,
  input  logic [LATW-1:0]  issue_lat,
  input  logic [ADDRW-1:0] src1_addr,
  input  logic [ADDRW-1:0] src2_addr,
  input  logic             src1_used,
  input  logic             src2_used,
  input  logic             hold,
  input  logic             flush,
  output logic             stall,
  output logic             src1_fwd,
  output logic             src2_fwd,
  output logic [LATW-1:0]  src1_stage,
  output logic [LATW-1:0]  src2_stage,
  output logic             busy_any,
  output logic             lat_err
);
  logic [NREGS-1:0]           busy;
  logic [NREGS-1:0]           load;
  logic [NREGS-1:0][LATW-1:0] cnt;
  logic s1_hit, s2_hit, s1_near, s2_near, raw, waw, lat_ok, accept;

  assign busy[0] = 1'b0;
  assign cnt[0]  = '0;
  assign load[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NREGS; r++) begin : g_ent
      assign load[r] = accept && (issue_rd == ADDRW'(r));
      hazard_scoreboard_entry #(.MAXLAT(MAXLAT), .LATW(LATW), .KILL_WIN(KILL_WIN)) u_ent (
        .clock    (clock),
        .reset    (reset),
        .hold     (hold),
        .flush    (flush),
        .load     (load[r]),
        .load_cnt (issue_lat),
        .busy     (busy[r]),
        .cnt      (cnt[r])
      );
    end
  endgenerate

  always_comb begin
    s1_hit  = src1_used && (src1_addr != '0) && busy[src1_addr];
    s2_hit  = src2_used && (src2_addr != '0) && busy[src2_addr];
    s1_near = int'(cnt[src1_addr]) <= FWD_WIN;
    s2_near = int'(cnt[src2_addr]) <= FWD_WIN;
    raw     = (s1_hit && !s1_near) || (s2_hit && !s2_near);
    waw     = issue_wen && (issue_rd != '0) && busy[issue_rd] && (issue_lat < cnt[issue_rd]);
    stall   = issue_valid && (raw || waw);
    lat_ok  = (issue_lat != '0) && (int'(issue_lat) <= MAXLAT);
    accept  = issue_valid && !stall && !hold && !flush && issue_wen &&
              (issue_rd != '0) && lat_ok;
    src1_fwd   = s1_hit && s1_near;
    src2_fwd   = s2_hit && s2_near;
    src1_stage = src1_fwd ? cnt[src1_addr] : '0;
    src2_stage = src2_fwd ? cnt[src2_addr] : '0;
  end

  assign busy_any = |busy;

  // evaluated every cycle so the flag is a single-cycle pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lat_err <= 1'b0;
    else        lat_err <= issue_valid && issue_wen && !stall && !lat_ok;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard against a tick-based
// reference model that tracks absolute issue/completion times per register.

module tb_hazard_scoreboard;
  localparam int NREGS = 32, ADDRW = 5, MAXLAT = 8, LATW = 4, FWD_WIN = 2, KILL_WIN = 2;

  logic clock = 1'b0, reset = 1'b0;
  logic issue_valid = 0, issue_wen = 0, src1_used = 0, src2_used = 0, hold = 0, flush = 0;
  logic [ADDRW-1:0] issue_rd = '0, src1_addr = '0, src2_addr = '0;
  logic [LATW-1:0]  issue_lat = '0;
  logic stall, src1_fwd, src2_fwd, busy_any, lat_err;
  logic [LATW-1:0] src1_stage, src2_stage;

  hazard_scoreboard #(.NREGS(NREGS), .ADDRW(ADDRW), .MAXLAT(MAXLAT), .LATW(LATW),
                      .FWD_WIN(FWD_WIN), .KILL_WIN(KILL_WIN)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .src1_addr(src1_addr), .src2_addr(src2_addr),
    .src1_used(src1_used), .src2_used(src2_used), .hold(hold), .flush(flush),
    .stall(stall), .src1_fwd(src1_fwd), .src2_fwd(src2_fwd), .src1_stage(src1_stage),
    .src2_stage(src2_stage), .busy_any(busy_any), .lat_err(lat_err));

  always #5 clock = ~clock;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // model: an entry is pending while tick < done; tick only advances when not held
  int tick = 0;
  bit m_val[NREGS];
  int m_iss[NREGS], m_done[NREGS];
  bit e_lat_err = 0;

  function automatic bit mbusy(int r);
    return r != 0 && m_val[r] && m_done[r] > tick;
  endfunction

  function automatic int mcnt(int r);
    return mbusy(r) ? m_done[r] - tick : 0;
  endfunction

  function automatic int mage(int r);
    return (tick - m_iss[r] > MAXLAT) ? MAXLAT : tick - m_iss[r];
  endfunction

  function automatic int npend();
    int n = 0;
    for (int r = 0; r < NREGS; r++) if (mbusy(r)) n++;
    return n;
  endfunction

  task automatic seval(input int a, input bit u, output bit raw, output bit fw, output int st);
    bit hz;
    hz  = u && a != 0 && mbusy(a);
    raw = hz && mcnt(a) > FWD_WIN;
    fw  = hz && mcnt(a) <= FWD_WIN;
    st  = fw ? mcnt(a) : 0;
  endtask

  task automatic step(input bit v, input bit w, input int rd, input int lat,
                      input int a1, input bit u1, input int a2, input bit u2,
                      input bit h, input bit f);
    bit raw1, fw1, raw2, fw2, waw, stl, latok, acc;
    int st1, st2;
    issue_valid = v; issue_wen = w; issue_rd = ADDRW'(rd); issue_lat = LATW'(lat);
    src1_addr = ADDRW'(a1); src1_used = u1; src2_addr = ADDRW'(a2); src2_used = u2;
    hold = h; flush = f;
    @(negedge clock);
    seval(a1, u1, raw1, fw1, st1);
    seval(a2, u2, raw2, fw2, st2);
    waw = w && rd != 0 && mbusy(rd) && lat < mcnt(rd);
    stl = v && (raw1 || raw2 || waw);
    chk("stall", 32'(stall), 32'(stl));
    chk("src1_fwd", 32'(src1_fwd), 32'(fw1));
    chk("src2_fwd", 32'(src2_fwd), 32'(fw2));
    chk("src1_stage", 32'(src1_stage), st1);
    chk("src2_stage", 32'(src2_stage), st2);
    chk("busy_any", 32'(busy_any), 32'(npend() != 0));
    chk("lat_err", 32'(lat_err), 32'(e_lat_err));
    latok = lat >= 1 && lat <= MAXLAT;
    acc = v && !stl && !h && !f && w && rd != 0 && latok;
    e_lat_err = v && w && !stl && !latok;
    if (!h) begin
      if (f)
        for (int r = 1; r < NREGS; r++)
          if (mbusy(r) && mage(r) < KILL_WIN) m_val[r] = 0;
      tick++;
      if (acc) begin
        m_val[rd] = 1; m_iss[rd] = tick; m_done[rd] = tick + lat;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // async reset mid-cycle, with a reader aimed at a possibly busy register
  task automatic do_reset(input int probe);
    issue_valid = 1; issue_wen = 1; issue_rd = ADDRW'(probe); issue_lat = 4'd1;
    src1_addr = ADDRW'(probe); src1_used = 1; src2_addr = ADDRW'(probe); src2_used = 1;
    hold = 0; flush = 0;
    #1 reset = 1'b0;
    #1;
    chk("rst_busy_any", 32'(busy_any), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd", 32'({src1_fwd, src2_fwd}), 0);
    chk("rst_stage", 32'({src1_stage, src2_stage}), 0);
    chk("rst_lat_err", 32'(lat_err), 0);
    for (int r = 0; r < NREGS; r++) m_val[r] = 0;
    e_lat_err = 0;
    @(posedge clock);
    #3 reset = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) begin m_val[r] = 0; m_iss[r] = 0; m_done[r] = 0; end
    @(posedge clock);
    do_reset(5);
    // bypass after a short producer
    step(1, 1, 5, 3, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    // long producer read as src2: RAW stalls then bypass
    step(1, 1, 7, 6, 0, 0, 0, 0, 0, 0);
    repeat (7) step(1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
    // single-cycle producer and rd=0 writes
    step(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 3, 1, 3, 1, 0, 0);
    step(1, 1, 0, 4, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    // WAW: shorter latency blocked, longer latency accepted
    step(1, 1, 9, 5, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 1, 9, 2, 0, 0, 0, 0, 0, 0);
    step(1, 1, 9, 5, 9, 0, 9, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    // flush kills young entries only
    step(1, 1, 4, 6, 0, 0, 0, 0, 0, 0);
    step(1, 1, 6, 6, 0, 0, 0, 0, 0, 0);
    step(1, 1, 10, 3, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 4, 1, 6, 1, 0, 0);
    step(1, 1, 4, 6, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 1, 6, 6, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) step(1, 0, 0, 0, 4, 1, 6, 1, 0, 0);
    // hold freezes state; bad latencies flag lat_err
    step(1, 1, 8, 5, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    repeat (4) step(1, 1, 11, 3, 8, 1, 8, 1, 1, 0);
    repeat (3) step(1, 0, 0, 0, 8, 1, 0, 0, 0, 0);
    step(1, 1, 12, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 1, 12, MAXLAT + 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 12, MAXLAT, 0, 0, 0, 0, 0, 0);
    do_reset(12);
    step(1, 1, 12, 3, 12, 1, 0, 0, 0, 0);
    idle();
    // random traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(int'($urandom_range(1, 9)));
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 9)), int'($urandom_range(0, MAXLAT + 2)),
           int'($urandom_range(0, 9)), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 9)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32: number of architectural registers; register 0 is hardwired zero.
REQ-002 SHALL have parameter ADDRW, default $clog2(NREGS): register address width.
REQ-003 SHALL have parameter MAXLAT, default 8: maximum producer latency in cycles, 1..15.
REQ-004 SHALL have parameter LATW, default $clog2(MAXLAT+1): latency/counter width.
REQ-005 SHALL have parameter FWD_WIN, default 2: remaining-latency threshold at or below which a result is on the bypass network.
REQ-006 SHALL have parameter KILL_WIN, default 2: entries younger than KILL_WIN cycles are squashable by flush.
REQ-007 clock  in  1  single clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 issue_valid  in  1  decode-stage instruction presented for issue.
REQ-010 issue_wen  in  1  instruction writes a destination register.
REQ-011 issue_rd  in  ADDRW  destination register.
REQ-012 issue_lat  in  LATW  cycles from issue until register-file write.
REQ-013 src1_addr, src2_addr  in  ADDRW each  source registers.
REQ-014 src1_used, src2_used  in  1 each  source is actually read (0 for U/J types, etc.).
REQ-015 hold  in  1  downstream pipeline frozen; all counters hold.
REQ-016 flush  in  1  branch redirect; squash young entries.
REQ-017 stall  out  1  issue blocked this cycle (combinational).
REQ-018 src1_fwd, src2_fwd  out  1 each  source served from bypass network.
REQ-019 src1_stage, src2_stage  out  LATW each  remaining count of the producing entry; selects the bypass tap.
REQ-020 busy_any  out  1  at least one entry pending (registered-state derived).
REQ-021 lat_err  out  1  registered one-cycle pulse: illegal issue_lat rejected.

Function
REQ-022 Per register r (1..NREGS-1) SHALL hold busy[r], cnt[r] (LATW), age[r] (LATW, saturating at MAXLAT).
REQ-023 Source hazard: used && addr!=0 && busy[addr]; cnt>FWD_WIN -> RAW stall; cnt<=FWD_WIN -> fwd=1, stage=cnt[addr]; no hazard -> fwd=0, stage=0.
REQ-024 WAW stall: issue_wen && issue_rd!=0 && busy[issue_rd] && issue_lat<cnt[issue_rd].
REQ-025 stall = issue_valid && (RAW on either source || WAW); stall SHALL be 0 when issue_valid=0.
REQ-026 Accepted issue = issue_valid && !stall && !hold && !flush && issue_wen && issue_rd!=0 && 1<=issue_lat<=MAXLAT; sets busy=1, cnt=issue_lat, age=0 at the edge.
REQ-027 issue_lat==0 or >MAXLAT with issue_valid && issue_wen && !stall: no entry created, lat_err=1 next cycle only.
REQ-028 Each cycle with hold=0, every busy entry: cnt-=1, age+=1 (saturating); entry reaching cnt=0 clears busy at that edge (register-file write committed).
REQ-029 hold=1: cnt, age, busy of all entries frozen; issues not accepted; outputs still reflect current state.
REQ-030 flush=1 (hold=0): entries with age<KILL_WIN clear busy; older entries decrement normally; same-cycle issue discarded.
REQ-031 Issue to register whose entry expires the same edge: new issue wins (busy=1, cnt=issue_lat).
REQ-032 Register 0 SHALL never become busy and never produce stall or fwd.
REQ-033 busy_any = OR of busy[]; src_stage width rules: counters never wrap below 0.

Reset
REQ-034 reset low SHALL asynchronously clear all busy, cnt, age and lat_err; stall=0, fwd=0, stage=0, busy_any=0 while low and after release.
REQ-035 Reset mid-operation SHALL discard all pending entries; first edge after release accepts issue normally.

Verification
REQ-036 Issue x5 lat=3; next cycle read x5 -> cnt=2<=FWD_WIN: stall=0, src1_fwd=1, src1_stage=2; cycle after: stage=1.
REQ-037 Issue x7 lat=6; next cycle read x7 as src2 -> stall=1 for cycles cnt=5,4,3; cnt=2: stall=0, src2_fwd=1, src2_stage=2.
REQ-038 Issue x3 lat=1; next cycle: busy_any=0, read x3 -> fwd=0, stall=0; issue rd=0 lat=4 -> busy_any stays 0.
REQ-039 x9 busy cnt=4; issue x9 lat=2 -> stall=1 (WAW); with src_used=0 and lat=5 -> accepted, cnt=5.
REQ-040 Issue x4 lat=6, x6 lat=6 one cycle apart; flush after x6 (ages 1,0 with KILL_WIN=2) -> both cleared; repeat with x4 age 2 -> x4 survives, cnt continues.
REQ-041 x8 cnt=3, hold high 4 cycles -> cnt stays 3, stall/fwd stable; issue_lat=0 -> lat_err pulses 1 cycle; reset low mid-run -> busy_any=0 immediately.
